// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared constants, loader state encoding and byte-lane helper
//                for the instruction-memory loader and its byte RAM.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package imem_pkg;

  localparam int IMEM_ADDR_W    = 8;
  localparam int IMEM_DEPTH     = 256;
  localparam int MAX_LOAD_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } loader_state_e;

  // Little-endian lane select: k=0 is the least significant byte.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] k);
    return word[{k, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_byte_ram
//  Description : 2**ADDR_W x 8 instruction memory. Synchronous byte write
//                port, combinational 32-bit little-endian read
//                {m[a+3],m[a+2],m[a+1],m[a]} with address wrap.
//  Ports       : clk      - clock
//                we_i     - byte write enable
//                waddr_i  - byte write address
//                wdata_i  - byte write data
//                raddr_i  - read byte address (lowest byte of the word)
//                rdata_o  - 32-bit little-endian read data
//  Revision    : 1.0  initial release
// ============================================================================
module imem_byte_ram
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] w_raddr1;
  logic [ADDR_W-1:0] w_raddr2;
  logic [ADDR_W-1:0] w_raddr3;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Upper byte addresses wrap modulo the memory depth.
  assign w_raddr1 = raddr_i + ADDR_W'(1);
  assign w_raddr2 = raddr_i + ADDR_W'(2);
  assign w_raddr3 = raddr_i + ADDR_W'(3);

  assign rdata_o = {mem_q[w_raddr3], mem_q[w_raddr2], mem_q[w_raddr1], mem_q[raddr_i]};

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Accepts 32-bit instruction words over a valid/ready stream
//                and writes each as four consecutive byte writes (LSB first)
//                into the instruction memory. busy stalls fetch during a load.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                start       - load request (sampled in IDLE only)
//                base_addr   - first byte address of the load
//                word_cnt    - words to load (saturates at 64)
//                in_valid    - in_word valid
//                in_word     - instruction word
//                in_ready    - loader accepts in_word this cycle
//                mem_we      - byte write strobe
//                mem_addr    - byte write address
//                mem_wdata   - byte write data
//                busy        - load in progress (fetch stall)
//                done        - one-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOAD_WORDS);

  loader_state_e     state_q;
  logic [ADDR_W-1:0] ptr_q;      // address of the next byte to be presented
  logic [CNT_W-1:0]  remain_q;   // words still to be accepted
  logic [31:0]       word_q;
  logic [1:0]        byte_q;     // lane currently on mem_wdata
  logic [CNT_W-1:0]  load_cnt_d;

  assign load_cnt_d = (word_cnt > MAX_CNT) ? MAX_CNT : word_cnt;

  // All outputs are registered: each transition sets up the values the
  // outputs must show in the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      remain_q  <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q    <= base_addr;
            remain_q <= load_cnt_d;
            busy     <= 1'b1;
            if (load_cnt_d == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q  <= ACCEPT;
              in_ready <= 1'b1;
            end
          end
        end

        ACCEPT: begin
          // in_ready is held high for the whole ACCEPT state.
          if (in_valid) begin
            word_q    <= in_word;
            byte_q    <= 2'd0;
            remain_q  <= remain_q - 1'b1;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= ptr_q;
            mem_wdata <= byte_of(in_word, 2'd0);
            ptr_q     <= ptr_q + 1'b1;
            state_q   <= WRITE;
          end
        end

        WRITE: begin
          if (byte_q == 2'd3) begin
            mem_we <= 1'b0;
            if (remain_q != '0) begin
              state_q  <= ACCEPT;
              in_ready <= 1'b1;
            end else begin
              state_q <= DONE;
              done    <= 1'b1;
            end
          end else begin
            byte_q    <= byte_q + 2'd1;
            mem_addr  <= ptr_q;
            mem_wdata <= byte_of(word_q, byte_q + 2'd1);
            ptr_q     <= ptr_q + 1'b1;
          end
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader driving imem_byte_ram.
//                A byte-level memory model derived from the load rules
//                predicts every write, its cycle, and the read-back words.
//  Ports       : none (top-level bench)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;
  import imem_pkg::*;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_cnt;
  logic              in_valid;
  logic [31:0]       in_word;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  imem_byte_ram #(.ADDR_W(ADDR_W)) ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_addr),
    .wdata_i (mem_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Cycle stamp and passive capture of bus activity, sampled on negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int hs_cyc_q[$];
  int done_cyc_q[$];
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_wdata));
      wr_cyc_q.push_back(cyc);
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) hs_cyc_q.push_back(cyc);
    if (done === 1'b1) done_cyc_q.push_back(cyc);
    if (busy === 1'b1) busy_cnt++;
  end

  // Reference memory: byte value plus "has been written" flag.
  int          model_mem[256];
  bit          model_known[256];
  logic [31:0] wq[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    hs_cyc_q.delete();
    done_cyc_q.delete();
    busy_cnt = 0;
  endtask

  // Expected j-th byte write of a load: consecutive addresses mod 256, LSB first.
  function automatic int exp_addr(input int base, input int j);
    return (base + j) % 256;
  endfunction

  function automatic int exp_data(input int j);
    logic [31:0] w;
    w = wq[j / 4];
    return int'((w >> (8 * (j % 4))) & 32'hFF);
  endfunction

  task automatic model_write(input int base, input int nbytes);
    for (int j = 0; j < nbytes; j++) begin
      model_mem[exp_addr(base, j)]   = exp_data(j);
      model_known[exp_addr(base, j)] = 1'b1;
    end
  endtask

  task automatic check_read(input int a);
    logic [31:0] exp;
    logic [31:0] mask;
    for (int k = 0; k < 4; k++) begin
      exp[8*k +: 8]  = 8'(model_mem[(a + k) % 256]);
      mask[8*k +: 8] = model_known[(a + k) % 256] ? 8'hFF : 8'h00;
    end
    rd_addr = 8'(a);
    #1;
    if (mask != 32'h0) check("read_back", 64'(rd_data & mask), 64'(exp & mask));
  endtask

  task automatic run_load(input int base, input int cnt, input int gap_idx,
                          input int gap_len, input bit spurious, input int spur_base);
    int n;
    int start_cyc;
    int guard;
    int exp_done;
    int ec;
    n = (cnt > MAX_LOAD_WORDS) ? MAX_LOAD_WORDS : cnt;
    clear_capture();
    base_addr = 8'(base);
    word_cnt  = 7'(cnt);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_idx) begin
        in_valid = 1'b0;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
        repeat (gap_len) tick();
      end
      in_valid = 1'b1;
      in_word  = wq[i];
      guard = 0;
      while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
      tick();
      in_valid = 1'b0;
      in_word  = $urandom();
      if (spurious && i == 0) begin
        start     = 1'b1;
        base_addr = 8'(spur_base);
        word_cnt  = 7'd5;
        tick();
        start     = 1'b0;
        base_addr = 8'(base);
      end
    end
    guard = 0;
    while (done_cyc_q.size() == 0 && guard < 500) begin tick(); guard++; end
    repeat (3) tick();

    check("handshakes", 64'(hs_cyc_q.size()), 64'(n));
    check("write_count", 64'(wr_addr_q.size()), 64'(4 * n));
    for (int j = 0; j < wr_addr_q.size() && j < 4 * n; j++) begin
      ec = (j / 4 < hs_cyc_q.size()) ? hs_cyc_q[j / 4] + 1 + (j % 4) : -1;
      check("byte_write",
            {16'd0, 32'(wr_cyc_q[j]), 8'(wr_addr_q[j]), 8'(wr_data_q[j])},
            {16'd0, 32'(ec), 8'(exp_addr(base, j)), 8'(exp_data(j))});
    end
    for (int i = 0; i < hs_cyc_q.size(); i++) begin
      if (i != gap_idx)
        check("hs_cycle", 64'(hs_cyc_q[i]), 64'((i == 0) ? start_cyc + 1 : hs_cyc_q[i-1] + 5));
    end
    if (n == 0) exp_done = start_cyc + 1;
    else exp_done = (hs_cyc_q.size() == n) ? hs_cyc_q[n-1] + 5 : -1;
    check("done_pulses", 64'(done_cyc_q.size()), 64'd1);
    check("done_cycle", 64'((done_cyc_q.size() > 0) ? done_cyc_q[0] : -2), 64'(exp_done));
    check("busy_cycles", 64'(busy_cnt), 64'(exp_done - start_cyc));
    model_write(base, 4 * n);
  endtask

  initial begin
    int b;
    int g;
    rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
    in_valid = 1'b0; in_word = '0; rd_addr = '0;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single word at 0.
    wq = {32'h00500093};
    run_load(0, 1, -1, 0, 1'b0, 0);
    rd_addr = 8'h00;
    #1;
    check("read_single", 64'(rd_data), 64'h00500093);

    // Three words with a 5-cycle valid gap before word 2.
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom());
    run_load(8'h10, 3, 1, 5, 1'b0, 0);
    rd_addr = 8'h18;
    #1;
    check("read_word3", 64'(rd_data), 64'(wq[2]));
    check_read(8'h10);
    check_read(8'h14);

    // Address wrap inside a word.
    wq = {32'hAABBCCDD};
    run_load(8'hFE, 1, -1, 0, 1'b0, 0);
    rd_addr = 8'hFE;
    #1;
    check("read_wrap", 64'(rd_data), 64'hAABBCCDD);

    // Zero-length load.
    wq.delete();
    run_load(8'h40, 0, -1, 0, 1'b0, 0);

    // Saturating load covers the whole memory.
    b = $urandom_range(0, 255);
    for (int i = 0; i < 64; i++) wq.push_back($urandom());
    run_load(b, 100, -1, 0, 1'b0, 0);
    for (int i = 0; i < 64; i++) check_read((b + 4 * i) % 256);

    // Reset after byte 1 of word 2.
    clear_capture();
    b = $urandom_range(0, 255);
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom());
    base_addr = 8'(b); word_cnt = 7'd3;
    in_valid = 1'b1; in_word = wq[0]; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    in_word = wq[1];
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_mem_we", 64'(mem_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    tick();
    tick();
    check("midrst_writes", 64'(wr_addr_q.size()), 64'd6);
    for (int j = 0; j < wr_addr_q.size() && j < 6; j++)
      check("midrst_byte", {48'd0, 8'(wr_addr_q[j]), 8'(wr_data_q[j])},
            {48'd0, 8'(exp_addr(b, j)), 8'(exp_data(j))});
    model_write(b, 6);
    check_read(b);
    check_read((b + 4) % 256);

    // Normal load after reset.
    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back($urandom());
    b = $urandom_range(0, 255);
    run_load(b, 2, -1, 0, 1'b0, 0);
    check_read(b);

    // start during WRITE is ignored.
    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back($urandom());
    b = $urandom_range(0, 255);
    run_load(b, 2, -1, 0, 1'b1, (b + 8'h40) % 256);
    check_read(b);
    check_read((b + 4) % 256);

    // Random loads, some with a valid gap.
    for (int r = 0; r < 4; r++) begin
      wq.delete();
      for (int i = 0; i < 6; i++) wq.push_back($urandom());
      b = $urandom_range(0, 255);
      g = $urandom_range(0, 3);
      run_load(b, $urandom_range(1, 6), (g == 0) ? -1 : g, $urandom_range(1, 4), 1'b0, 0);
      check_read(b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
